// File: rtl/trace_pkg.sv
// Shared definitions for the write-back trace path: field widths and the
// packed record layout {cyc, pc, we, rd, data}.
package trace_pkg;

  localparam int PC_W   = 32;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;
  localparam int DROP_W = 16;

  // Everything in a record except the cycle stamp, whose width is a
  // parameter of the emitter and is therefore prepended there.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } trace_body_t;

  localparam int BODY_W = $bits(trace_body_t);

  // Total packed record width for a given cycle-stamp width.
  function automatic int rec_width(input int cyc_w);
    return cyc_w + BODY_W;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO for trace records. The head entry is read straight out
// of the storage array so a record pushed at one edge is presented right
// after it; full/empty come from the occupancy counter, not the pointers.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign level   = level_reg;
  assign rdata   = mem[rd_ptr_reg];

  // Storage write; no reset so the array can map onto RAM primitives.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_emitter.sv
// Captures PC and MEM/WB write-back each active cycle, stamps it with a
// cycle count and streams the records out over valid/ready.
module wb_trace_emitter
  import trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CYC_W      = 16,
  parameter bit SKIP_X0    = 1'b1,
  parameter bit LOG_ALL_PC = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic                   wb_we_i,
  input  logic [RD_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]      wb_data_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [CYC_W-1:0]       trace_cyc_o,
  output logic [PC_W-1:0]        trace_pc_o,
  output logic                   trace_we_o,
  output logic [RD_W-1:0]        trace_rd_o,
  output logic [DATA_W-1:0]      trace_data_o,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int REC_W = rec_width(CYC_W);

  logic [CYC_W-1:0]  cyc_reg;
  logic [DROP_W-1:0] drop_cnt_reg;
  logic              overflow_reg;

  logic              wb_valid;
  logic              cap;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  trace_body_t       body_in;
  trace_body_t       body_out;
  logic [REC_W-1:0]  wdata;
  logic [REC_W-1:0]  rdata;

  // A write-back counts unless it targets x0 and x0 is being filtered.
  assign wb_valid = wb_we_i && !(SKIP_X0 && (wb_addr_i == '0));
  assign cap      = start_i && (wb_valid || LOG_ALL_PC);

  assign trace_valid_o = !empty;
  assign pop           = trace_valid_o && trace_ready_i;
  assign push          = cap && (!full || pop);
  assign drop          = cap && full && !pop;

  // Pack the record; rd/data are zeroed when there is no real write-back.
  always_comb begin
    body_in      = '0;
    body_in.pc   = pc_i;
    body_in.we   = wb_valid;
    body_in.rd   = wb_valid ? wb_addr_i : '0;
    body_in.data = wb_valid ? wb_data_i : '0;
  end

  assign wdata    = {cyc_reg, body_in};
  assign body_out = rdata[BODY_W-1:0];

  // Outputs read zero while empty so stale storage never leaks out.
  assign trace_cyc_o  = empty ? '0 : rdata[REC_W-1 -: CYC_W];
  assign trace_pc_o   = empty ? '0 : body_out.pc;
  assign trace_we_o   = empty ? 1'b0 : body_out.we;
  assign trace_rd_o   = empty ? '0 : body_out.rd;
  assign trace_data_o = empty ? '0 : body_out.data;

  assign drop_cnt_o = drop_cnt_reg;
  assign overflow_o = overflow_reg;

  // Cycle stamp: advances only while the CPU runs, wraps at 2^CYC_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_reg <= '0;
    end else if (start_i) begin
      cyc_reg <= cyc_reg + 1'b1;
    end
  end

  // Lost-record accounting: saturating counter plus sticky flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

endmodule

// File: tb/tb_wb_trace_emitter.sv
// Scoreboard bench: three emitters (default, x0 logged, every-PC logged)
// share the write-back stimulus but each has its own start/ready.
module tb_wb_trace_emitter;

  typedef struct packed {
    logic [15:0] cyc;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        start [3];
  logic        ready [3];
  logic        valid [3];
  logic [15:0] cyc_o [3];
  logic [31:0] pc_o  [3];
  logic        we_o  [3];
  logic [4:0]  rd_o  [3];
  logic [31:0] data_o[3];
  logic [15:0] drop  [3];
  logic        ovf   [3];
  logic [3:0]  level [3];

  rec_t act [3];
  rec_t exp_q [3][$];
  rec_t head;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_trace_emitter #(.DEPTH(8), .CYC_W(16), .SKIP_X0(1'b1), .LOG_ALL_PC(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .pc_i(pc), .wb_we_i(wb_we),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data), .trace_valid_o(valid[0]),
    .trace_ready_i(ready[0]), .trace_cyc_o(cyc_o[0]), .trace_pc_o(pc_o[0]),
    .trace_we_o(we_o[0]), .trace_rd_o(rd_o[0]), .trace_data_o(data_o[0]),
    .drop_cnt_o(drop[0]), .overflow_o(ovf[0]), .level_o(level[0]));

  wb_trace_emitter #(.DEPTH(8), .CYC_W(16), .SKIP_X0(1'b0), .LOG_ALL_PC(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .pc_i(pc), .wb_we_i(wb_we),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data), .trace_valid_o(valid[1]),
    .trace_ready_i(ready[1]), .trace_cyc_o(cyc_o[1]), .trace_pc_o(pc_o[1]),
    .trace_we_o(we_o[1]), .trace_rd_o(rd_o[1]), .trace_data_o(data_o[1]),
    .drop_cnt_o(drop[1]), .overflow_o(ovf[1]), .level_o(level[1]));

  wb_trace_emitter #(.DEPTH(8), .CYC_W(16), .SKIP_X0(1'b1), .LOG_ALL_PC(1'b1)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .pc_i(pc), .wb_we_i(wb_we),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data), .trace_valid_o(valid[2]),
    .trace_ready_i(ready[2]), .trace_cyc_o(cyc_o[2]), .trace_pc_o(pc_o[2]),
    .trace_we_o(we_o[2]), .trace_rd_o(rd_o[2]), .trace_data_o(data_o[2]),
    .drop_cnt_o(drop[2]), .overflow_o(ovf[2]), .level_o(level[2]));

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      act[k] = {cyc_o[k], pc_o[k], we_o[k], rd_o[k], data_o[k]};
    end
  end

  // Monitor: whenever a record is presented, it must match the oldest
  // expected record; it is retired from the scoreboard when accepted.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (valid[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rec dut%0d: got cyc=%0d pc=%h we=%b rd=%0d data=%h, want no record",
                     k, act[k].cyc, act[k].pc, act[k].we, act[k].rd, act[k].data);
          end else begin
            head = exp_q[k][0];
            if (act[k] !== head) begin
              errors++;
              $display("FAIL rec dut%0d: got cyc=%0d pc=%h we=%b rd=%0d data=%h, want cyc=%0d pc=%h we=%b rd=%0d data=%h",
                       k, act[k].cyc, act[k].pc, act[k].we, act[k].rd, act[k].data,
                       head.cyc, head.pc, head.we, head.rd, head.data);
            end else begin
              $display("rec dut%0d cyc=%0d pc=%h we=%b rd=%0d data=%h ready=%b",
                       k, act[k].cyc, act[k].pc, act[k].we, act[k].rd, act[k].data, ready[k]);
            end
            if (ready[k]) void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end else begin
      $display("check %s = %h", name, got);
    end
  endtask

  task automatic exp_push(input int k, input logic [15:0] c, input logic [31:0] p,
                          input logic w, input logic [4:0] r, input logic [31:0] d);
    exp_q[k].push_back({c, p, w, r, d});
  endtask

  task automatic set_wb(input logic [31:0] p, input logic w, input logic [4:0] a, input logic [31:0] d);
    pc = p; wb_we = w; wb_addr = a; wb_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b1;
    end
    set_wb(32'h0, 1'b0, 5'd0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("reset_valid", {31'd0, valid[0]}, 32'd0);
    chk("reset_level", {28'd0, level[0]}, 32'd0);
    chk("reset_drop",  {16'd0, drop[0]}, 32'd0);
    chk("reset_ovf",   {31'd0, ovf[0]}, 32'd0);
    chk("reset_cyc",   {16'd0, cyc_o[0]}, 32'd0);
    chk("reset_data",  data_o[0], 32'd0);

    // First active cycle: one record, visible next cycle, gone after pop
    start[0] = 1'b1;
    set_wb(32'd4, 1'b1, 5'd8, 32'd5);
    exp_push(0, 16'd0, 32'd4, 1'b1, 5'd8, 32'd5);
    tick();
    chk("first_valid", {31'd0, valid[0]}, 32'd1);
    set_wb(32'd8, 1'b0, 5'd0, 32'd0);
    tick();
    chk("first_drained", {31'd0, valid[0]}, 32'd0);

    // x0 write-backs filtered on the default instance
    set_wb(32'd12, 1'b1, 5'd0, 32'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("skip_x0_level", {28'd0, level[0]}, 32'd0);
    end
    start[0] = 1'b0;
    set_wb(32'd0, 1'b0, 5'd0, 32'd0);
    tick();

    // Same x0 stimulus on the unfiltered instance
    start[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wb(32'd100 + 32'(4 * i), 1'b1, 5'd0, 32'd11 + 32'(i));
      exp_push(1, 16'(i), 32'd100 + 32'(4 * i), 1'b1, 5'd0, 32'd11 + 32'(i));
      tick();
    end
    start[1] = 1'b0;
    set_wb(32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("x0_logged_drained", {28'd0, level[1]}, 32'd0);

    // Overflow: ready low for DEPTH+3 captures
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start[0] = 1'b1;
    ready[0] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_wb(32'h200 + 32'(4 * i), 1'b1, 5'd3, 32'h10 + 32'(i));
      if (i < 8) exp_push(0, 16'(i), 32'h200 + 32'(4 * i), 1'b1, 5'd3, 32'h10 + 32'(i));
      tick();
    end
    chk("ovf_level", {28'd0, level[0]}, 32'd8);
    chk("ovf_drop",  {16'd0, drop[0]}, 32'd3);
    chk("ovf_flag",  {31'd0, ovf[0]}, 32'd1);
    chk("ovf_head_cyc", {16'd0, cyc_o[0]}, 32'd0);

    // Full with simultaneous pop and capture: no drop
    ready[0] = 1'b1;
    set_wb(32'h300, 1'b1, 5'd4, 32'hAA);
    exp_push(0, 16'd11, 32'h300, 1'b1, 5'd4, 32'hAA);
    tick();
    chk("full_pop_push_level", {28'd0, level[0]}, 32'd8);
    chk("full_pop_push_drop",  {16'd0, drop[0]}, 32'd3);
    start[0] = 1'b0;
    set_wb(32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("drain_level", {28'd0, level[0]}, 32'd0);
    chk("ovf_sticky",  {31'd0, ovf[0]}, 32'd1);

    // Every-PC logging with no write-back
    start[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wb(32'(4 * i), 1'b0, 5'd7, 32'hDEAD);
      exp_push(2, 16'(i), 32'(4 * i), 1'b0, 5'd0, 32'd0);
      tick();
    end
    start[2] = 1'b0;
    set_wb(32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("log_all_drained", {28'd0, level[2]}, 32'd0);

    // Reset mid-stream discards queued records
    start[0] = 1'b1;
    ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_wb(32'h500 + 32'(4 * i), 1'b1, 5'd9, 32'h50 + 32'(i));
      exp_push(0, 16'd12 + 16'(i), 32'h500 + 32'(4 * i), 1'b1, 5'd9, 32'h50 + 32'(i));
      tick();
    end
    chk("pre_reset_level", {28'd0, level[0]}, 32'd5);
    rst = 1'b1;
    start[0] = 1'b0;
    set_wb(32'd0, 1'b0, 5'd0, 32'd0);
    exp_q[0].delete();
    tick();
    rst = 1'b0;
    chk("mid_reset_valid", {31'd0, valid[0]}, 32'd0);
    chk("mid_reset_level", {28'd0, level[0]}, 32'd0);
    chk("mid_reset_drop",  {16'd0, drop[0]}, 32'd0);
    chk("mid_reset_ovf",   {31'd0, ovf[0]}, 32'd0);
    start[0] = 1'b1;
    ready[0] = 1'b1;
    set_wb(32'h400, 1'b1, 5'd2, 32'h77);
    exp_push(0, 16'd0, 32'h400, 1'b1, 5'd2, 32'h77);
    tick();
    start[0] = 1'b0;
    set_wb(32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("post_reset_drained", {28'd0, level[0]}, 32'd0);

    // Every expected record must have been delivered
    for (int k = 0; k < 3; k++) begin
      chk("scoreboard_empty", 32'(exp_q[k].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_emitter.md
Name: wb_trace_emitter

Overview:
- Producer side of the CPU state-dump path. Captures each cycle's PC plus the MEM/WB register write-back and queues them as trace records.
- Streams records out over a valid/ready interface, so a bench or host consumer can log architectural state without peeking into hierarchy.
- Sits beside the CPU top level. Fed from the PC module output and the mem_wb pipeline register outputs.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CYC_W, 16, cycle-stamp width.
- SKIP_X0, 1, when 1, write-backs to x0 are not recorded.
- LOG_ALL_PC, 0, when 1, a record is produced every active cycle, even with no write-back.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  CPU running; capture enabled only while high
- pc_i  in  32  current PC (pc_o of the PC module)
- wb_we_i  in  1  mem_wb reg_write_o
- wb_addr_i  in  5  mem_wb reg_write_data_addr_o
- wb_data_i  in  32  mem_wb reg_write_data_o
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  consumer accepts record
- trace_cyc_o  out  CYC_W  cycle stamp of record
- trace_pc_o  out  32  PC of record
- trace_we_o  out  1  record carries a write-back
- trace_rd_o  out  5  destination register
- trace_data_o  out  32  write-back value
- drop_cnt_o  out  16  records lost to overflow, saturating
- overflow_o  out  1  sticky; set on first drop
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i=1 at a clock edge): cycle counter=0, FIFO empty, trace_valid_o=0, all trace_* data outputs=0, drop_cnt_o=0, overflow_o=0, level_o=0. Reset has priority over every other event. Reset mid-stream discards all queued records.
- Cycle counter:
  - Increments by 1 each clock while start_i=1; holds while start_i=0.
  - Wraps modulo 2^CYC_W.
  - The stamp stored is the counter value before that edge's increment. The first active cycle is stamped 0.
- Capture condition (evaluated each clock with start_i=1): cap = (wb_we_i && !(SKIP_X0 && wb_addr_i==0)) || LOG_ALL_PC.
- Record content:
  - trace_we_o = wb_we_i && !(SKIP_X0 && wb_addr_i==0).
  - When trace_we_o=0, trace_rd_o and trace_data_o are 0.
- Push:
  - If cap and the FIFO is not full, the record is written at that edge.
  - If full but a pop occurs in the same cycle (trace_valid_o && trace_ready_i), the push succeeds.
- Drop:
  - If cap, the FIFO is full, and there is no pop that cycle, the record is discarded.
  - drop_cnt_o increments, saturating at 16'hFFFF.
  - overflow_o sets and stays set until reset.
- Pop: occurs on trace_valid_o && trace_ready_i at the clock edge; the next entry is presented the following cycle.
- Output stream:
  - trace_valid_o = FIFO non-empty; outputs are driven from the head entry (registered storage, no combinational path from capture inputs).
  - Latency: a record captured at edge N is visible at edge N+1 when the FIFO was empty.
  - While valid=1 and ready=0, all trace_* outputs hold stable.
- Simultaneous push and pop on an empty FIFO: the popped entry does not exist, so only the push happens. No bypass; level becomes 1.
- level_o: 0..DEPTH; +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers: log2(DEPTH)-bit read/write indices wrap naturally. Full/empty are derived from the level counter.
- start_i low: no capture and the counter frozen, but draining continues.

Decomposition:
- Package trace_pkg:
  - Record field widths (PC_W=32, RD_W=5, DATA_W=32).
  - Packed record layout {cyc, pc, we, rd, data} and its total width.
  - Drop-counter width 16.
- Sub-module trace_fifo: synchronous single-clock FIFO.
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, level.
- wb_trace_emitter owns: cycle counter, capture filter, drop/overflow logic, record pack/unpack.

Test Plan:
- Reset then start_i=1; wb_we_i=1, wb_addr_i=8, wb_data_i=5, pc_i=4 on the first active cycle; ready=1 -> next cycle valid=1, cyc=0, pc=4, we=1, rd=8, data=5; following cycle valid=0.
- SKIP_X0=1, wb_we_i=1, wb_addr_i=0 for 3 cycles -> no records, level_o=0. Same stimulus with SKIP_X0=0 -> 3 records, rd=0.
- ready=0 with write-backs every cycle for DEPTH+3 cycles -> level_o=8, drop_cnt_o=3, overflow_o=1. Head holds cyc=0 stable throughout. Draining yields cyc 0..7 in order.
- FIFO full with ready=1 and a capture in the same cycle -> no drop, level stays 8, drop_cnt_o unchanged.
- LOG_ALL_PC=1, wb_we_i=0, pc stepping 0,4,8 -> three records with we=0, rd=0, data=0, and pc 0,4,8.
- Five records queued, then rst_i=1 for one cycle -> next cycle valid=0, level_o=0, drop_cnt_o=0, overflow_o=0; after start, first stamp is 0.
